// File: rtl/serial_addsub_nbit_pkg.sv
// Shared types for the serial add/subtract unit.
package serial_addsub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Encodings of the select input
    localparam logic ADD = 1'b0;
    localparam logic SUB = 1'b1;

endpackage

// File: rtl/serial_addsub_nbit_if.sv
// Request/result bundle between the operand registers and the serial add/sub unit.
interface serial_addsub_nbit_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             select;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] Sum;
    logic             Cout;
    logic             Overflow;

    // Requester side: issues operations, observes results
    modport master (
        output start, select, A, B, Cin,
        input  busy, done, Sum, Cout, Overflow
    );

    // Unit side: accepts operations, produces results
    modport slave (
        input  start, select, A, B, Cin,
        output busy, done, Sum, Cout, Overflow
    );
endinterface

// File: rtl/serial_addsub_nbit_adder_digit.sv
// One DIGIT-bit ripple-carry slice; the only arithmetic in the unit.
module adder_digit #(
    parameter int DIGIT = 2
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             cin,
    output logic [DIGIT-1:0] sum,
    output logic             cout,
    output logic             c_msb
);
    logic [DIGIT:0] c;

    // Ripple the carry through the slice; c_msb is the carry entering the top bit
    always_comb begin
        c    = '0;
        sum  = '0;
        c[0] = cin;
        for (int i = 0; i < DIGIT; i++) begin
            sum[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1]   = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
        end
        cout  = c[DIGIT];
        c_msb = c[DIGIT-1];
    end
endmodule

// File: rtl/serial_addsub_nbit.sv
// Multi-cycle add/subtract: WIDTH-bit operands consumed DIGIT bits per clock
// through a single shared slice, with start/busy/done handshake.
module serial_addsub_nbit
    import serial_addsub_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 2
) (
    input  logic clk,
    input  logic reset_n,
    serial_addsub_nbit_if.slave bus
);
    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] opa_q, opb_q, res_q, res_d;
    logic [WIDTH-1:0] sum_q;
    logic             carry_q, cout_q, ovf_q;
    logic [CW-1:0]    cnt_q;
    logic [DIGIT-1:0] slice_sum;
    logic             slice_cout, slice_cmsb;
    logic             load, last;

    adder_digit #(.DIGIT(DIGIT)) u_digit (
        .a     (opa_q[DIGIT-1:0]),
        .b     (opb_q[DIGIT-1:0]),
        .cin   (carry_q),
        .sum   (slice_sum),
        .cout  (slice_cout),
        .c_msb (slice_cmsb)
    );

    // New slice bits enter at the top, so after N steps digit 0 sits at the LSB
    generate
        if (DIGIT == WIDTH) begin : g_single
            assign res_d = slice_sum;
        end else begin : g_shift
            assign res_d = {slice_sum, res_q[WIDTH-1:DIGIT]};
        end
    endgenerate

    // start is only honoured outside RUN; DONE->RUN gives back-to-back issue
    assign load = bus.start && (state_q != RUN);
    assign last = (cnt_q == CW'(N - 1));

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = RUN;
            RUN:     if (last)      state_d = DONE;
            DONE:    state_d = bus.start ? RUN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Handshake outputs decoded from the state register
    always_comb begin
        bus.busy = (state_q == RUN);
        bus.done = (state_q == DONE);
    end

    // Operand/result shift registers, carry and digit counter
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            opa_q   <= '0;
            opb_q   <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
        end else if (load) begin
            // Subtract as A + ~B + ~Cin
            opa_q   <= bus.A;
            opb_q   <= bus.B ^ {WIDTH{bus.select == SUB}};
            carry_q <= bus.Cin ^ (bus.select == SUB);
            cnt_q   <= '0;
        end else if (state_q == RUN) begin
            opa_q   <= opa_q >> DIGIT;
            opb_q   <= opb_q >> DIGIT;
            res_q   <= res_d;
            carry_q <= slice_cout;
            cnt_q   <= cnt_q + 1'b1;
        end
    end

    // Visible results update only on the final digit, never mid-operation
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sum_q  <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else if (state_q == RUN && last) begin
            sum_q  <= res_d;
            cout_q <= slice_cout;
            ovf_q  <= slice_cmsb ^ slice_cout;
        end
    end

    assign bus.Sum      = sum_q;
    assign bus.Cout     = cout_q;
    assign bus.Overflow = ovf_q;
endmodule

// File: tb/tb_serial_addsub_nbit.sv
// Directed + random checks of serial_addsub_nbit at DIGIT = 2, 1 and 8.
module tb_serial_addsub_nbit;
    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       start = 1'b0, sel = 1'b0, cin = 1'b0;
    logic [7:0] a = '0, b = '0;
    int         n_chk = 0, n_err = 0;

    always #5 clk = ~clk;

    serial_addsub_nbit_if #(.WIDTH(8)) if2 ();
    serial_addsub_nbit_if #(.WIDTH(8)) if1 ();
    serial_addsub_nbit_if #(.WIDTH(8)) if8 ();

    assign if2.start = start; assign if2.select = sel; assign if2.A = a; assign if2.B = b; assign if2.Cin = cin;
    assign if1.start = start; assign if1.select = sel; assign if1.A = a; assign if1.B = b; assign if1.Cin = cin;
    assign if8.start = start; assign if8.select = sel; assign if8.A = a; assign if8.B = b; assign if8.Cin = cin;

    serial_addsub_nbit #(.WIDTH(8), .DIGIT(2)) u_d2 (.clk(clk), .reset_n(reset_n), .bus(if2));
    serial_addsub_nbit #(.WIDTH(8), .DIGIT(1)) u_d1 (.clk(clk), .reset_n(reset_n), .bus(if1));
    serial_addsub_nbit #(.WIDTH(8), .DIGIT(8)) u_d8 (.clk(clk), .reset_n(reset_n), .bus(if8));

    // Captured {Cout, Overflow, Sum} at each done pulse, plus done counts
    logic [9:0] r2, r1, r8;
    int         n2 = 0, n1 = 0, n8 = 0;

    always @(posedge clk) begin #1; if (if2.done) begin r2 = {if2.Cout, if2.Overflow, if2.Sum}; n2++; end end
    always @(posedge clk) begin #1; if (if1.done) begin r1 = {if1.Cout, if1.Overflow, if1.Sum}; n1++; end end
    always @(posedge clk) begin #1; if (if8.done) begin r8 = {if8.Cout, if8.Overflow, if8.Sum}; n8++; end end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // Reference: {Cout, Overflow, Sum}
    function automatic logic [9:0] ref_model(input logic s, input logic [7:0] x, input logic [7:0] y, input logic ci);
        logic [8:0] full;
        logic [7:0] yy;
        logic       ov;
        yy   = s ? ~y : y;
        full = {1'b0, x} + {1'b0, yy} + {8'd0, ci ^ s};
        ov   = (x[7] == yy[7]) && (full[7] != x[7]);
        return {full[8], ov, full[7:0]};
    endfunction

    // Issue one op to all three units and compare each result
    task automatic run_op(input string tag, input logic s, input logic [7:0] av, input logic [7:0] bv,
                          input logic ci, input logic [9:0] exp);
        int b2, b1, b8, t;
        b2 = n2; b1 = n1; b8 = n8; t = 0;
        @(negedge clk);
        start = 1'b1; sel = s; a = av; b = bv; cin = ci;
        @(negedge clk);
        start = 1'b0; sel = ~s; a = 8'($urandom); b = 8'($urandom); cin = ~ci;
        while ((n2 == b2 || n1 == b1 || n8 == b8) && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk({tag, "/timeout"}, (t < 20), 1);
        chk({tag, "/d2"}, r2, exp);
        chk({tag, "/d1"}, r1, exp);
        chk({tag, "/d8"}, r8, exp);
    endtask

    initial begin
        int t, base;
        logic [7:0] ra, rb;
        logic       rs, rc;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_out", {if2.busy, if2.done, if2.Cout, if2.Overflow, if2.Sum}, 0);
        reset_n = 1'b1;
        @(negedge clk);

        // Timing at DIGIT=2: busy for 4 cycles after the start edge, then done
        start = 1'b1; sel = 1'b0; a = 8'h01; b = 8'h01; cin = 1'b0;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("t_busy%0d", k), {if2.busy, if2.done}, 2'b10);
            @(negedge clk);
        end
        chk("t_done", {if2.busy, if2.done}, 2'b01);
        chk("t_res", {if2.Cout, if2.Overflow, if2.Sum}, 10'h002);
        @(negedge clk);
        chk("t_drop", {if2.busy, if2.done}, 2'b00);
        repeat (10) @(negedge clk);

        // start held through RUN (no reload) and into DONE (back-to-back)
        start = 1'b1; sel = 1'b0; a = 8'h01; b = 8'h01; cin = 1'b0;
        @(negedge clk);
        a = 8'h10; b = 8'h20;
        repeat (3) @(negedge clk);
        chk("b2b_norld_busy", if2.busy, 1);
        @(negedge clk);
        chk("b2b_first_done", if2.done, 1);
        chk("b2b_first_sum", if2.Sum, 8'h02);
        @(negedge clk);
        start = 1'b0;
        t = 1;
        while (!if2.done && t < 20) begin
            chk($sformatf("b2b_hold%0d", t), if2.Sum, 8'h02);
            @(negedge clk);
            t++;
        end
        chk("b2b_gap", t, 5);
        chk("b2b_second_sum", if2.Sum, 8'h30);
        repeat (12) @(negedge clk);

        // Async reset in RUN cycle 2: outputs clear at once, no done
        start = 1'b1; sel = 1'b0; a = 8'h33; b = 8'h11; cin = 1'b0;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("rst_pre_busy", if2.busy, 1);
        reset_n = 1'b0;
        #1;
        chk("rst_mid_out", {if2.busy, if2.done, if2.Cout, if2.Overflow, if2.Sum}, 0);
        @(negedge clk);
        reset_n = 1'b1;
        base = n2;
        repeat (8) @(negedge clk);
        chk("rst_nodone", n2 - base, 0);
        run_op("post_rst", 1'b0, 8'h0A, 8'h05, 1'b0, 10'h00F);

        // Add boundaries
        run_op("add_ff_01", 1'b0, 8'hFF, 8'h01, 1'b0, 10'h200);
        run_op("add_7f_01", 1'b0, 8'h7F, 8'h01, 1'b0, 10'h180);
        run_op("add_03_02c", 1'b0, 8'h03, 8'h02, 1'b1, 10'h006);
        run_op("add_01_01", 1'b0, 8'h01, 8'h01, 1'b0, 10'h002);

        // Subtract
        run_op("sub_03_02", 1'b1, 8'h03, 8'h02, 1'b0, 10'h201);
        run_op("sub_02_03", 1'b1, 8'h02, 8'h03, 1'b0, 10'h0FF);
        run_op("sub_80_01", 1'b1, 8'h80, 8'h01, 1'b0, 10'h37F);
        run_op("sub_05_02b", 1'b1, 8'h05, 8'h02, 1'b1, 10'h202);

        // Random vectors against the model
        for (int i = 0; i < 1000; i++) begin
            ra = 8'($urandom); rb = 8'($urandom);
            rs = 1'($urandom); rc = 1'($urandom);
            run_op($sformatf("rnd%0d", i), rs, ra, rb, rc, ref_model(rs, ra, rb, rc));
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
